// File: rtl/axi4lite_regbank_slave_if.sv
// AXI4-Lite bus bundle for the register-bank slave: master drives requests, slave drives responses.
interface axi4lite_regbank_slave_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite slave register bank: NUM_REGS words with byte strobes, independent AW/W buffering,
// single outstanding read, SLVERR on out-of-range words, and flat export of all words.
module axi4lite_regbank_slave #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi4lite_regbank_slave_if.slave        s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  aw_ok, ar_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_addr_lsbs;

    // Byte-offset bits never reach the decode; fold them here so they count as consumed.
    assign unused_addr_lsbs = ^{s_axi.awaddr, s_axi.araddr};

    assign ar_idx = s_axi.araddr[ADDR_WIDTH-1:IDX_LSB];
    assign ar_ok  = {1'b0, ar_idx} < NUM_REGS_W;
    assign aw_ok  = {1'b0, aw_idx_q} < NUM_REGS_W;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    // Each word is its own flop group; it only changes on a commit that decodes to it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (commit && aw_ok && (aw_idx_q == IDX_W'(gi))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            word_d[b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
        end
    endgenerate

    // Read mux sees pre-commit contents, so a read racing a write gets the old word.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        aw_hs  = s_axi.awvalid && awready_q;
        w_hs   = s_axi.wvalid && wready_q;
        ar_hs  = s_axi.arvalid && arready_q;
        commit = aw_full_q && w_full_q && !bvalid_q;

        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.awaddr[ADDR_WIDTH-1:IDX_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.wdata;
            w_strb_d = s_axi.wstrb;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_ok ? rd_word : '0;
            rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Self-checking bench for axi4lite_regbank_slave: directed scenarios plus randomized traffic
// checked against an array model of the register bank.
module tb_axi4lite_regbank_slave;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*DW-1:0] regs_o;

    axi4lite_regbank_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_regbank_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axi  (bus),
        .regs_o (regs_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [DW-1:0] model [NR];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [3:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    function automatic bit in_range(input logic [AW-1:0] addr);
        return int'(addr) / 4 < NR;
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] word_of(input int i);
        return regs_o[i*DW +: DW];
    endfunction

    // Stimulus tasks are entered and left on a falling edge.
    task automatic send_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output bit ok);
        bit aw_done, w_done, aw_fire, w_fire;
        aw_done = 0; w_done = 0; ok = 0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.wvalid = 1'b0;  w_done = 1;  end
            if (aw_done && w_done) begin ok = 1; break; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output bit ok);
        ok = 0; resp = 2'bxx;
        bus.bready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (bus.bvalid) begin
                resp = bus.bresp; ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        send_aw_w(addr, data, strb, ok);
        resp = 2'bxx;
        if (ok) wait_b(resp, ok);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp, output bit ok);
        bit fire, got;
        ok = 0; got = 0; data = 'x; resp = 2'bxx;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            fire = bus.arvalid && bus.arready;
            @(negedge clk);
            if (fire) begin bus.arvalid = 1'b0; got = 1; break; end
        end
        bus.arvalid = 1'b0;
        if (got) begin
            for (int c = 0; c < 50; c++) begin
                if (bus.rvalid) begin
                    data = bus.rdata; resp = bus.rresp; ok = 1;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
            end
        end
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp,
                 bus.rresp, bus.rdata, regs_o} !== '0) begin
                $display("FAIL reset_outputs: got awr=%b wr=%b arr=%b bv=%b rv=%b rdata=%h regs=%h, want all 0",
                         bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rdata, regs_o);
            end else pass_cnt++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            $display("FAIL reset_release: got aw/w/ar ready=%b%b%b bv=%b rv=%b, want 111 0 0",
                     bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid);
        end else pass_cnt++;
        for (int i = 0; i < NR; i++) model[i] = '0;
        $display("reset: released, readies checked");
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp; logic [DW-1:0] data; bit ok;
        bus.awaddr = 5'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        total_cnt++;
        if (bus.bvalid !== 1'b0) $display("FAIL same_cycle_bvalid_early: got %b want 0", bus.bvalid);
        else pass_cnt++;
        @(negedge clk);
        model[2] = merge(model[2], 32'hDEADBEEF, 4'hF);
        total_cnt++;
        if ({bus.bvalid, bus.bresp} !== 3'b100)
            $display("FAIL same_cycle_bresp: got bvalid=%b bresp=%b want 1 00", bus.bvalid, bus.bresp);
        else pass_cnt++;
        total_cnt++;
        if (regs_o !== model_flat()) $display("FAIL same_cycle_regs: got %h want %h", regs_o, model_flat());
        else pass_cnt++;
        wait_b(resp, ok);
        axi_read(5'h08, data, resp, ok);
        total_cnt++;
        if (!ok || data !== model[2] || resp !== 2'b00)
            $display("FAIL same_cycle_read: ok=%0d got %h/%b want %h/00", ok, data, resp, model[2]);
        else pass_cnt++;
        $display("write 0x08 <= deadbeef, read back %h resp %b", data, resp);
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; bit ok;
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, resp, ok);
        model[1] = 32'hFFFFFFFF;
        total_cnt++;
        if (!ok || resp !== 2'b00) $display("FAIL w_first_prefill: ok=%0d resp=%b want 00", ok, resp);
        else pass_cnt++;
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (3) begin
            total_cnt++;
            if (bus.wready !== 1'b0 || word_of(1) !== model[1])
                $display("FAIL w_first_hold: wready=%b word1=%h want 0 %h", bus.wready, word_of(1), model[1]);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.awaddr = 5'h04; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        total_cnt++;
        if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0)
            $display("FAIL w_first_precommit: wready=%b bvalid=%b want 0 0", bus.wready, bus.bvalid);
        else pass_cnt++;
        @(negedge clk);
        model[1] = merge(model[1], 32'h11223344, 4'b0101);
        total_cnt++;
        if (bus.wready !== 1'b1 || bus.bvalid !== 1'b1 || word_of(1) !== model[1])
            $display("FAIL w_first_commit: wready=%b bvalid=%b word1=%h want 1 1 %h",
                     bus.wready, bus.bvalid, word_of(1), model[1]);
        else pass_cnt++;
        wait_b(resp, ok);
        $display("W before AW: word1 = %h", word_of(1));
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [DW-1:0] data; bit ok;
        axi_write(5'h18, 32'h000000AA, 4'hF, resp, ok);
        total_cnt++;
        if (!ok || resp !== 2'b10) $display("FAIL slverr_bresp: ok=%0d got %b want 10", ok, resp);
        else pass_cnt++;
        total_cnt++;
        if (regs_o !== model_flat()) $display("FAIL slverr_regs: got %h want %h", regs_o, model_flat());
        else pass_cnt++;
        axi_read(5'h1C, data, resp, ok);
        total_cnt++;
        if (!ok || resp !== 2'b10 || data !== '0)
            $display("FAIL slverr_read: ok=%0d got %h/%b want 0/10", ok, data, resp);
        else pass_cnt++;
        $display("out of range: bresp/rresp checked, rdata %h", data);
    endtask

    task automatic test_bready_stall();
        logic [1:0] resp; bit ok;
        int i1, i2; logic [DW-1:0] d1, d2; logic [3:0] s2;
        i1 = $urandom_range(0, NR-1); i2 = $urandom_range(0, NR-1);
        d1 = $urandom; d2 = $urandom; s2 = 4'($urandom_range(1, 15));
        bus.bready = 1'b0;
        send_aw_w(5'(i1*4), d1, 4'hF, ok);
        @(negedge clk);
        model[i1] = d1;
        total_cnt++;
        if (!ok || bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || regs_o !== model_flat())
            $display("FAIL stall_first: ok=%0d bvalid=%b bresp=%b regs=%h want 1 00 %h",
                     ok, bus.bvalid, bus.bresp, regs_o, model_flat());
        else pass_cnt++;
        send_aw_w(5'(i2*4), d2, s2, ok);
        repeat (4) begin
            total_cnt++;
            if (!ok || bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0 ||
                bus.wready !== 1'b0 || regs_o !== model_flat())
                $display("FAIL stall_hold: ok=%0d bv=%b bresp=%b awr=%b wr=%b regs=%h want 1 00 0 0 %h",
                         ok, bus.bvalid, bus.bresp, bus.awready, bus.wready, regs_o, model_flat());
            else pass_cnt++;
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        total_cnt++;
        if (bus.bvalid !== 1'b0 || regs_o !== model_flat())
            $display("FAIL stall_release: bvalid=%b regs=%h want 0 %h", bus.bvalid, regs_o, model_flat());
        else pass_cnt++;
        @(negedge clk);
        model[i2] = merge(model[i2], d2, s2);
        total_cnt++;
        if (bus.bvalid !== 1'b1 || regs_o !== model_flat())
            $display("FAIL stall_second_commit: bvalid=%b regs=%h want 1 %h", bus.bvalid, regs_o, model_flat());
        else pass_cnt++;
        wait_b(resp, ok);
        $display("bready stall: word%0d=%h word%0d=%h", i1, word_of(i1), i2, word_of(i2));
    endtask

    task automatic test_read_on_commit();
        logic [1:0] resp; logic [DW-1:0] data, old; bit ok;
        axi_write(5'h08, 32'd5, 4'hF, resp, ok);
        model[2] = 32'd5;
        old = model[2];
        bus.awaddr = 5'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'd9; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 5'h08; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        model[2] = 32'd9;
        total_cnt++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== old || bus.rresp !== 2'b00 || word_of(2) !== model[2])
            $display("FAIL race_read: rvalid=%b rdata=%h rresp=%b word2=%h want 1 %h 00 %h",
                     bus.rvalid, bus.rdata, bus.rresp, word_of(2), old, model[2]);
        else pass_cnt++;
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== old || bus.arready !== 1'b0)
                $display("FAIL race_hold: rvalid=%b rdata=%h arready=%b want 1 %h 0",
                         bus.rvalid, bus.rdata, bus.arready, old);
            else pass_cnt++;
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        total_cnt++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1)
            $display("FAIL race_rdone: rvalid=%b arready=%b want 0 1", bus.rvalid, bus.arready);
        else pass_cnt++;
        wait_b(resp, ok);
        axi_read(5'h08, data, resp, ok);
        total_cnt++;
        if (!ok || data !== model[2] || resp !== 2'b00)
            $display("FAIL race_followup: ok=%0d got %h/%b want %h/00", ok, data, resp, model[2]);
        else pass_cnt++;
        $display("read on commit: old %h, follow-up %h", old, data);
    endtask

    task automatic test_random();
        logic [1:0] resp, exp_resp; logic [DW-1:0] data, exp_data; bit ok;
        logic [AW-1:0] addr; logic [3:0] strb;
        for (int n = 0; n < 40; n++) begin
            addr = AW'($urandom_range(0, 31));
            exp_resp = in_range(addr) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom; strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, resp, ok);
                if (in_range(addr)) model[int'(addr) / 4] = merge(model[int'(addr) / 4], data, strb);
                total_cnt++;
                if (!ok || resp !== exp_resp)
                    $display("FAIL rand_write: addr=%h ok=%0d bresp=%b want %b", addr, ok, resp, exp_resp);
                else pass_cnt++;
                $display("rand write addr=%h data=%h strb=%b bresp=%b", addr, data, strb, resp);
            end else begin
                exp_data = in_range(addr) ? model[int'(addr) / 4] : '0;
                axi_read(addr, data, resp, ok);
                total_cnt++;
                if (!ok || resp !== exp_resp || data !== exp_data)
                    $display("FAIL rand_read: addr=%h ok=%0d got %h/%b want %h/%b",
                             addr, ok, data, resp, exp_data, exp_resp);
                else pass_cnt++;
                $display("rand read  addr=%h data=%h rresp=%b", addr, data, resp);
            end
        end
        total_cnt++;
        if (regs_o !== model_flat()) $display("FAIL rand_regs: got %h want %h", regs_o, model_flat());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] wresp, rresp; logic [DW-1:0] wdata, rdata, exp_rdata; bit wok, rok;
        int wi, ri; logic [3:0] strb;
        for (int n = 0; n < 8; n++) begin
            wi = $urandom_range(0, NR-1);
            ri = (wi + $urandom_range(1, NR-1)) % NR;
            wdata = $urandom; strb = 4'($urandom_range(0, 15));
            exp_rdata = model[ri];
            fork
                axi_write(5'(wi*4), wdata, strb, wresp, wok);
                axi_read(5'(ri*4 + 1), rdata, rresp, rok);
            join
            model[wi] = merge(model[wi], wdata, strb);
            total_cnt++;
            if (!wok || !rok || wresp !== 2'b00 || rresp !== 2'b00 || rdata !== exp_rdata ||
                regs_o !== model_flat())
                $display("FAIL concurrent: wok=%0d rok=%0d bresp=%b rresp=%b rdata=%h want %h regs=%h want %h",
                         wok, rok, wresp, rresp, rdata, exp_rdata, regs_o, model_flat());
            else pass_cnt++;
            $display("concurrent: write word%0d=%h, read word%0d=%h", wi, wdata, ri, rdata);
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_slverr();
        test_bready_stall();
        test_read_on_commit();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
